// File: rtl/adc0809_emu_if.sv
// CPU-side bus of the ADC0809 emulation: channel select, start strobe and result/status.
interface adc0809_emu_if;
  logic [2:0] ADDR;
  logic       START;
  logic [7:0] DOUT;
  logic       EOC;
  logic       EOC_PULSE;

  modport master (output ADDR, START, input DOUT, EOC, EOC_PULSE);
  modport slave  (input ADDR, START, output DOUT, EOC, EOC_PULSE);
endinterface

// File: rtl/adc0809_emu.sv
// ADC0809 emulation: 8-channel sample-and-hold with a CE-paced conversion delay
// and a registered result latch, EOC level and one-cycle EOC pulse.
module adc0809_emu #(
  parameter int CONV_CYCLES = 64
) (
  input  logic           MCLK,
  input  logic           RESET_N,
  input  logic           CE,
  input  logic [63:0]    AIN,
  adc0809_emu_if.slave   bus
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [7:0] LastCnt = 8'(CONV_CYCLES - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] sample_q;
  logic [7:0] dout_q;
  logic       eoc_q;
  logic       eoc_pulse_q;
  logic [7:0] ain_ch [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ain
      assign ain_ch[gi] = AIN[8*gi +: 8];
    end
  endgenerate

  assign cnt_d = cnt_q + 8'd1;

  // START has priority over everything, including a coincident final CE.
  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      sample_q    <= 8'd0;
      dout_q      <= 8'd0;
      eoc_q       <= 1'b1;
      eoc_pulse_q <= 1'b0;
    end else begin
      eoc_pulse_q <= 1'b0;
      if (bus.START) begin
        sample_q <= ain_ch[bus.ADDR];
        cnt_q    <= 8'd0;
        state_q  <= CONV;
        eoc_q    <= 1'b0;
      end else if (state_q == CONV && CE) begin
        if (cnt_q == LastCnt) begin
          dout_q      <= sample_q;
          eoc_q       <= 1'b1;
          eoc_pulse_q <= 1'b1;
          state_q     <= IDLE;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  end

  assign bus.DOUT      = dout_q;
  assign bus.EOC       = eoc_q;
  assign bus.EOC_PULSE = eoc_pulse_q;

endmodule

// File: tb/tb_adc0809_emu.sv
// Directed bench for adc0809_emu with CONV_CYCLES=4: stimulus pushes expected results,
// a monitor pops and checks them whenever EOC_PULSE is seen.
module tb_adc0809_emu;
  localparam logic [7:0] IDLE_VAL = 8'h80;

  logic        MCLK = 1'b0;
  logic        RESET_N;
  logic        CE;
  logic [63:0] AIN;

  adc0809_emu_if bus ();

  adc0809_emu #(.CONV_CYCLES(4)) dut (
    .MCLK    (MCLK),
    .RESET_N (RESET_N),
    .CE      (CE),
    .AIN     (AIN),
    .bus     (bus.slave)
  );

  always #5 MCLK = ~MCLK;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         pulse_cnt = 0;
  logic [7:0] exp_q [$];
  logic       prev_pulse = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, req);
    end else begin
      $display("ok   %s: %02h", name, act);
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] v);
    AIN[8*ch +: 8] = v;
  endtask

  // One MCLK: drive on the falling edge, return 1 ns after the rising edge.
  task automatic cyc(input logic start, input logic [2:0] addr, input logic ce);
    @(negedge MCLK);
    bus.START = start;
    bus.ADDR  = addr;
    CE        = ce;
    @(posedge MCLK);
    #1;
  endtask

  // n ADC clocks, CE every 5th MCLK.
  task automatic run_ce(input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) cyc(1'b0, 3'd0, 1'b0);
      cyc(1'b0, 3'd0, 1'b1);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge MCLK) begin
    if (bus.EOC_PULSE === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got EOC_PULSE=1 with DOUT=%02h expected no completion", bus.DOUT);
      end else begin
        check("mon_dout", bus.DOUT, exp_q.pop_front());
        check("mon_eoc", {7'd0, bus.EOC}, 8'd1);
      end
      if (prev_pulse) check("mon_pulse_width", 8'd2, 8'd1);
    end
    prev_pulse = (bus.EOC_PULSE === 1'b1);
  end

  initial begin
    AIN       = {4{IDLE_VAL, IDLE_VAL}};
    RESET_N   = 1'b0;
    bus.START = 1'b1;
    bus.ADDR  = 3'd2;
    CE        = 1'b1;
    set_ch(0, 8'h11); set_ch(1, 8'h10); set_ch(2, 8'h5A); set_ch(3, 8'h33);

    // Reset held 3 edges with START and CE active.
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'd2, 1'b1);
    check("rst_dout", bus.DOUT, 8'h00);
    check("rst_eoc", {7'd0, bus.EOC}, 8'd1);
    check("rst_pulse", {7'd0, bus.EOC_PULSE}, 8'd0);
    RESET_N = 1'b1;
    run_ce(6);
    check("idle_no_conv_eoc", {7'd0, bus.EOC}, 8'd1);

    // Basic conversion of ch2.
    cyc(1'b1, 3'd2, 1'b0);
    exp_q.push_back(8'h5A);
    check("basic_eoc_low", {7'd0, bus.EOC}, 8'd0);
    run_ce(3);
    check("basic_eoc_before_4th", {7'd0, bus.EOC}, 8'd0);
    run_ce(1);
    check("basic_dout", bus.DOUT, 8'h5A);
    check("basic_eoc_high", {7'd0, bus.EOC}, 8'd1);
    check("basic_pulse", {7'd0, bus.EOC_PULSE}, 8'd1);
    cyc(1'b0, 3'd0, 1'b0);
    check("basic_pulse_drop", {7'd0, bus.EOC_PULSE}, 8'd0);

    // Sample-and-hold: input changes right after START.
    cyc(1'b1, 3'd1, 1'b0);
    exp_q.push_back(8'h10);
    set_ch(1, 8'hF0);
    run_ce(4);
    check("hold_dout", bus.DOUT, 8'h10);

    // Restart mid-conversion.
    cyc(1'b1, 3'd0, 1'b0);
    run_ce(2);
    cyc(1'b1, 3'd3, 1'b0);
    exp_q.push_back(8'h33);
    run_ce(2);
    check("restart_no_early_eoc", {7'd0, bus.EOC}, 8'd0);
    check("restart_dout_held", bus.DOUT, 8'h10);
    run_ce(2);
    check("restart_dout", bus.DOUT, 8'h33);

    // START coincident with the final CE of a ch0 conversion.
    cyc(1'b1, 3'd0, 1'b0);
    run_ce(3);
    for (int j = 0; j < 4; j++) cyc(1'b0, 3'd0, 1'b0);
    cyc(1'b1, 3'd5, 1'b1);
    exp_q.push_back(8'h80);
    check("coll_eoc_low", {7'd0, bus.EOC}, 8'd0);
    check("coll_dout_held", bus.DOUT, 8'h33);
    run_ce(3);
    check("coll_eoc_still_low", {7'd0, bus.EOC}, 8'd0);
    run_ce(1);
    check("coll_dout", bus.DOUT, 8'h80);

    // Back-to-back START on the EOC rise cycle.
    cyc(1'b1, 3'd3, 1'b0);
    exp_q.push_back(8'h33);
    check("b2b_eoc_low", {7'd0, bus.EOC}, 8'd0);
    run_ce(4);
    check("b2b_dout", bus.DOUT, 8'h33);

    // Reset at CE count 2 of a ch2 conversion.
    cyc(1'b1, 3'd2, 1'b0);
    run_ce(2);
    RESET_N = 1'b0;
    cyc(1'b0, 3'd0, 1'b0);
    RESET_N = 1'b1;
    check("midrst_dout", bus.DOUT, 8'h00);
    check("midrst_eoc", {7'd0, bus.EOC}, 8'd1);
    run_ce(6);
    check("midrst_dout_after", bus.DOUT, 8'h00);
    check("midrst_eoc_after", {7'd0, bus.EOC}, 8'd1);

    cyc(1'b0, 3'd0, 1'b0);
    check("pulse_total", 8'(pulse_cnt), 8'd5);
    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
